// File: rtl/tictactoe_board.sv
// -----------------------------------------------------------------------------
// tictactoe_board
//
// Game-state engine for a two-player tic-tac-toe. Takes move requests from
// the button controller, validates them against the current board and turn,
// places marks, detects wins and draws, and auto-plays the lowest-index empty
// cell when the player to move idles for TURN_TIMEOUT cycles.
//
// Ports
//   Clk           in   system clock, rising edge
//   rst           in   asynchronous, active-low reset
//   playX         in   X move request level (acted on at its 0->1 edge)
//   playO         in   O move request level (acted on at its 0->1 edge)
//   position[3:0] in   target cell 0..8 row-major; 9..15 invalid
//   board[17:0]   out  cell i at board[2i+1:2i]: 00 empty, 01 X, 10 O
//   who[1:0]      out  01 X to move, 10 O to move, 00 game over
//   illegal_move  out  one-cycle pulse on a rejected move
//   winner[1:0]   out  00 none, 01 X, 10 O, 11 draw
//   game_over     out  high once the game has ended
//   move_count    out  marks placed so far, 0..9
//   timeout       out  one-cycle pulse when an auto-move is made
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module tictactoe_board #(
  parameter int unsigned TURN_TIMEOUT = 32'd500_000_000
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        playX,
  input  logic        playO,
  input  logic [3:0]  position,
  output logic [17:0] board,
  output logic [1:0]  who,
  output logic        illegal_move,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  move_count,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_WAIT      = 2'd0,
    S_CHECK     = 2'd1,
    S_GAME_OVER = 2'd2
  } state_e;

  localparam logic [1:0] MARK_NONE   = 2'b00;
  localparam logic [1:0] MARK_X      = 2'b01;
  localparam logic [1:0] MARK_O      = 2'b10;
  localparam logic [1:0] RESULT_DRAW = 2'b11;

  // A disabled timeout still needs a legal (1-bit) timer vector.
  localparam int unsigned TW = (TURN_TIMEOUT == 0) ? 1 : $clog2(TURN_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // True when mark m occupies any complete row, column or diagonal.
  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int i = 0; i < 9; i++) begin
      own[i] = (b[2*i +: 2] == m);
    end
    return (own[0] & own[1] & own[2]) |
           (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) |
           (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) |
           (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) |
           (own[2] & own[4] & own[6]);
  endfunction

  // Lowest-index empty cell; scanning downward lets the lowest hit win.
  function automatic logic [3:0] first_empty(input logic [17:0] b);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (b[2*i +: 2] == MARK_NONE) idx = 4'(i);
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,      state_d;
  logic [17:0]     board_q,      board_d;
  logic [1:0]      who_q,        who_d;
  logic [1:0]      winner_q,     winner_d;
  logic [3:0]      move_count_q, move_count_d;
  logic            illegal_q,    illegal_d;
  logic            timeout_q,    timeout_d;
  logic            game_over_q,  game_over_d;
  logic [TW-1:0]   timer_q,      timer_d;
  logic            play_x_q,     play_o_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic       req_x, req_o;
  logic       cur_req, other_req;
  logic       pos_empty;
  logic       legal;
  logic       reject;
  logic       timer_expired;
  logic [3:0] auto_cell;

  assign req_x = playX & ~play_x_q;
  assign req_o = playO & ~play_o_q;

  // Only the player whose turn it is gets evaluated; the other request can
  // only ever produce a rejection, and only when it arrives alone.
  assign cur_req   = (who_q == MARK_X) ? req_x : req_o;
  assign other_req = (who_q == MARK_X) ? req_o : req_x;

  always_comb begin
    pos_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (position == 4'(i)) pos_empty = (board_q[2*i +: 2] == MARK_NONE);
    end
  end

  assign legal         = cur_req & pos_empty;
  assign reject        = (cur_req & ~pos_empty) | (other_req & ~cur_req);
  assign timer_expired = (TURN_TIMEOUT != 0) && (timer_q == TIMER_LAST);
  assign auto_cell     = first_empty(board_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    board_d      = board_q;
    who_d        = who_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
    timer_d      = timer_q;
    game_over_d  = game_over_q;
    illegal_d    = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        // Saturate so a disabled timeout never wraps the counter.
        if (timer_q != TIMER_MAX) timer_d = timer_q + TW'(1);

        if (legal) begin
          for (int i = 0; i < 9; i++) begin
            if (position == 4'(i)) board_d[2*i +: 2] = who_q;
          end
          move_count_d = move_count_q + 4'd1;
          state_d      = S_CHECK;
        end else begin
          illegal_d = reject;
          if (timer_expired) begin
            for (int i = 0; i < 9; i++) begin
              if (auto_cell == 4'(i)) board_d[2*i +: 2] = who_q;
            end
            move_count_d = move_count_q + 4'd1;
            timeout_d    = 1'b1;
            state_d      = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        // who_q still names the player who just moved.
        if (has_line(board_q, who_q)) begin
          winner_d    = who_q;
          who_d       = MARK_NONE;
          game_over_d = 1'b1;
          state_d     = S_GAME_OVER;
        end else if (move_count_q == 4'd9) begin
          winner_d    = RESULT_DRAW;
          who_d       = MARK_NONE;
          game_over_d = 1'b1;
          state_d     = S_GAME_OVER;
        end else begin
          who_d   = (who_q == MARK_X) ? MARK_O : MARK_X;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end

      S_GAME_OVER: begin
        // Terminal until reset.
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_WAIT;
      board_q      <= '0;
      who_q        <= MARK_X;
      winner_q     <= MARK_NONE;
      move_count_q <= 4'd0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      timer_q      <= '0;
      play_x_q     <= 1'b0;
      play_o_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      board_q      <= board_d;
      who_q        <= who_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      timer_q      <= timer_d;
      // Edge-detect copies track the inputs in every state so a level held
      // through CHECK or GAME_OVER never turns into a late request.
      play_x_q     <= playX;
      play_o_q     <= playO;
    end
  end

  assign board        = board_q;
  assign who          = who_q;
  assign winner       = winner_q;
  assign move_count   = move_count_q;
  assign illegal_move = illegal_q;
  assign timeout      = timeout_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_tictactoe_board.sv
// -----------------------------------------------------------------------------
// Testbench for tictactoe_board (TURN_TIMEOUT = 16).
// A game-level reference model (cells array, whose turn, idle count) tracks
// the expected outputs cycle by cycle. Inputs change on the falling edge;
// outputs are compared 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tictactoe_board;

  localparam int T = 16;

  logic        Clk;
  logic        rst;
  logic        playX;
  logic        playO;
  logic [3:0]  position;
  logic [17:0] board;
  logic [1:0]  who;
  logic        illegal_move;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  tictactoe_board #(.TURN_TIMEOUT(T)) dut (
    .Clk          (Clk),
    .rst          (rst),
    .playX        (playX),
    .playO        (playO),
    .position     (position),
    .board        (board),
    .who          (who),
    .illegal_move (illegal_move),
    .winner       (winner),
    .game_over    (game_over),
    .move_count   (move_count),
    .timeout      (timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Reference model: game rules on plain integers
  // ---------------------------------------------------------------------------
  int  m_cells[9];     // 0 empty, 1 X, 2 O
  int  m_turn;         // 1 X, 2 O, 0 nobody
  int  m_result;       // 0 none, 1 X, 2 O, 3 draw
  int  m_placed;
  int  m_idle;         // cycles spent waiting in the current turn
  bit  m_over;
  bit  m_deciding;     // a mark was just placed; verdict due next cycle
  bit  m_prev_x, m_prev_o;
  bit  m_ill, m_to;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit wins(int m);
    bit w;
    w = 0;
    for (int l = 0; l < 8; l++) begin
      if (m_cells[lines[l][0]] == m && m_cells[lines[l][1]] == m &&
          m_cells[lines[l][2]] == m) w = 1;
    end
    return w;
  endfunction

  function automatic int model_board();
    int b;
    b = 0;
    for (int i = 0; i < 9; i++) b = b + (m_cells[i] << (2 * i));
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_cells[i] = 0;
    m_turn = 1; m_result = 0; m_placed = 0; m_idle = 0;
    m_over = 0; m_deciding = 0; m_prev_x = 0; m_prev_o = 0;
    m_ill = 0; m_to = 0;
  endtask

  task automatic model_step(bit x, bit o, int pos);
    bit rx, ro, mine, theirs, legal;
    int spot;
    rx = x && !m_prev_x;
    ro = o && !m_prev_o;
    m_prev_x = x;
    m_prev_o = o;
    m_ill = 0;
    m_to  = 0;
    if (m_over) begin
      // nothing happens once the game has ended
    end else if (m_deciding) begin
      m_deciding = 0;
      if (wins(m_turn)) begin
        m_result = m_turn; m_turn = 0; m_over = 1;
      end else if (m_placed == 9) begin
        m_result = 3; m_turn = 0; m_over = 1;
      end else begin
        m_turn = 3 - m_turn;
        m_idle = 0;
      end
    end else begin
      mine   = (m_turn == 1) ? rx : ro;
      theirs = (m_turn == 1) ? ro : rx;
      legal  = 0;
      if (mine && pos < 9) legal = (m_cells[pos] == 0);
      if (legal) begin
        m_cells[pos] = m_turn;
        m_placed++;
        m_deciding = 1;
      end else begin
        m_ill = mine || theirs;
        if (m_idle == T - 1) begin
          spot = -1;
          for (int i = 8; i >= 0; i--) if (m_cells[i] == 0) spot = i;
          m_cells[spot] = m_turn;
          m_placed++;
          m_deciding = 1;
          m_to = 1;
        end
      end
      m_idle++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model.board",        int'(board),        model_board());
    check("model.who",          int'(who),          m_turn);
    check("model.winner",       int'(winner),       m_result);
    check("model.move_count",   int'(move_count),   m_placed);
    check("model.illegal_move", int'(illegal_move), int'(m_ill));
    check("model.timeout",      int'(timeout),      int'(m_to));
    check("model.game_over",    int'(game_over),    int'(m_over));
  endtask

  task automatic check_reset_values(string tag);
    check({tag, ".board"},        int'(board),        0);
    check({tag, ".who"},          int'(who),          1);
    check({tag, ".winner"},       int'(winner),       0);
    check({tag, ".move_count"},   int'(move_count),   0);
    check({tag, ".illegal_move"}, int'(illegal_move), 0);
    check({tag, ".timeout"},      int'(timeout),      0);
    check({tag, ".game_over"},    int'(game_over),    0);
  endtask

  // One clock: drive on the falling edge, compare just after the rising edge.
  task automatic cycle(bit x, bit o, int pos);
    @(negedge Clk);
    playX    = x;
    playO    = o;
    position = 4'(pos);
    @(posedge Clk);
    model_step(x, o, pos);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    rst = 1'b0; playX = 1'b0; playO = 1'b0; position = 4'd0;
    #1;
    check_reset_values("reset");
    model_reset();
    @(negedge Clk);
    rst = 1'b1;
  endtask

  // A complete move: request edge, then release so the verdict cycle runs.
  task automatic mv(bit is_x, int pos);
    cycle(is_x, !is_x, pos);
    cycle(0, 0, pos);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    bit x;
    bit o;
    int pos;
    int exp_board;
    int exp_who;
    bit exp_ill;
    int exp_mc;
  } vec_t;

  vec_t vecs[12];
  int   saved_board;

  initial begin
    rst = 1'b0; playX = 1'b0; playO = 1'b0; position = 4'd0;

    // X at 4, then wrong-turn, occupied and out-of-range rejects, then O at 3.
    vecs[0]  = '{0, 0, 4,  'h000, 1, 0, 0};
    vecs[1]  = '{1, 0, 4,  'h100, 1, 0, 1};
    vecs[2]  = '{1, 0, 4,  'h100, 2, 0, 1};
    vecs[3]  = '{0, 0, 4,  'h100, 2, 0, 1};
    vecs[4]  = '{1, 0, 0,  'h100, 2, 1, 1};
    vecs[5]  = '{0, 0, 0,  'h100, 2, 0, 1};
    vecs[6]  = '{0, 1, 4,  'h100, 2, 1, 1};
    vecs[7]  = '{0, 0, 4,  'h100, 2, 0, 1};
    vecs[8]  = '{0, 1, 12, 'h100, 2, 1, 1};
    vecs[9]  = '{0, 0, 12, 'h100, 2, 0, 1};
    vecs[10] = '{0, 1, 3,  'h180, 2, 0, 2};
    vecs[11] = '{0, 0, 3,  'h180, 1, 0, 2};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].x, vecs[i].o, vecs[i].pos);
      check($sformatf("vec%0d.board", i),      int'(board),        vecs[i].exp_board);
      check($sformatf("vec%0d.who", i),        int'(who),          vecs[i].exp_who);
      check($sformatf("vec%0d.illegal", i),    int'(illegal_move), int'(vecs[i].exp_ill));
      check($sformatf("vec%0d.move_count", i), int'(move_count),   vecs[i].exp_mc);
    end

    // X wins on the top row; later requests are ignored.
    do_reset();
    mv(1, 0); mv(0, 3); mv(1, 1); mv(0, 4); mv(1, 2);
    check("win.winner",    int'(winner),    1);
    check("win.who",       int'(who),       0);
    check("win.game_over", int'(game_over), 1);
    check("win.board",     int'(board),     'h295);
    saved_board = int'(board);
    cycle(0, 1, 5);
    check("win.late_illegal", int'(illegal_move), 0);
    check("win.late_board",   int'(board),        saved_board);
    cycle(0, 0, 5);

    // Full board with no line.
    do_reset();
    mv(1, 0); mv(0, 1); mv(1, 2); mv(0, 4); mv(1, 3);
    mv(0, 5); mv(1, 7); mv(0, 6); mv(1, 8);
    check("draw.winner",     int'(winner),     3);
    check("draw.move_count", int'(move_count), 9);
    check("draw.game_over",  int'(game_over),  1);

    // O idles after X at 0: auto-move into cell 1 after T cycles in WAIT.
    do_reset();
    mv(1, 0);
    for (int i = 0; i < T - 1; i++) begin
      cycle(0, 0, 0);
      check("to.early_timeout", int'(timeout), 0);
    end
    cycle(0, 0, 0);
    check("to.pulse",      int'(timeout),    1);
    check("to.cell1",      int'(board[3:2]), 2);
    check("to.move_count", int'(move_count), 2);
    cycle(0, 0, 0);
    check("to.who",        int'(who),        1);
    check("to.pulse_end",  int'(timeout),    0);

    // A held request makes exactly one move.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    check("hold.move_count", int'(move_count), 1);
    check("hold.board",      int'(board),      'h001);
    check("hold.who",        int'(who),        2);
    cycle(0, 0, 0);

    // Asynchronous reset while in CHECK.
    do_reset();
    mv(1, 4);
    cycle(0, 1, 2);
    check("mid.board_before", int'(board), 'h120);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midcheck");
    model_reset();
    @(negedge Clk);
    playX = 1'b0; playO = 1'b0;
    @(negedge Clk);
    rst = 1'b1;
    cycle(0, 0, 0);

    // Random play against the model.
    for (int g = 0; g < 25; g++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        int r, p;
        bit rx, ro;
        r  = $urandom_range(0, 99);
        rx = (r < 25);
        ro = (r >= 20 && r < 45);
        p  = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        cycle(rx, ro, p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
